// File: rtl/l2_cache_pkg.sv
// Shared widths, FSM state encoding and address split for the L2 controller.
package l2_cache_pkg;
    localparam int S_OFFSET = 5;
    localparam int S_INDEX  = 4;
    localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
    localparam int S_BYTES  = 2**S_OFFSET;
    localparam int S_LINE   = 8*S_BYTES;
    localparam int NUM_SETS = 2**S_INDEX;
    localparam int NUM_WAYS = 4;
    localparam int WAY_W    = 2;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_e;

    typedef struct packed {
        logic [S_TAG-1:0]    tag;
        logic [S_INDEX-1:0]  index;
        logic [S_OFFSET-1:0] offset;
    } addr_t;

    function automatic addr_t split_addr(input logic [31:0] a);
        return addr_t'(a);
    endfunction
endpackage

// File: rtl/l2_tag_store.sv
// Per-way tag/valid/dirty arrays with 4-way compare for the selected set.
module l2_tag_store
    import l2_cache_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [S_INDEX-1:0]             index,
    input  logic [S_TAG-1:0]               req_tag,
    input  logic                           fill_we,
    input  logic [WAY_W-1:0]               fill_way,
    input  logic                           dirty_we,
    input  logic [WAY_W-1:0]               dirty_way,
    input  logic                           dirty_val,
    output logic                           hit,
    output logic [WAY_W-1:0]               hit_way,
    output logic                           has_invalid,
    output logic [WAY_W-1:0]               first_invalid,
    output logic [NUM_WAYS-1:0][S_TAG-1:0] way_tag,
    output logic [NUM_WAYS-1:0]            way_valid,
    output logic [NUM_WAYS-1:0]            way_dirty
);
    logic [NUM_SETS-1:0][NUM_WAYS-1:0][S_TAG-1:0] tag_q, tag_d;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]            valid_q, valid_d;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]            dirty_q, dirty_d;
    logic [NUM_WAYS-1:0]                          way_match;

    assign way_tag   = tag_q[index];
    assign way_valid = valid_q[index];
    assign way_dirty = dirty_q[index];

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        assign way_match[w] = valid_q[index][w] && (tag_q[index][w] == req_tag);
    end

    // Descending scan so the lowest-numbered way wins both encoders.
    always_comb begin
        hit           = 1'b0;
        hit_way       = '0;
        has_invalid   = 1'b0;
        first_invalid = '0;
        for (int w = NUM_WAYS-1; w >= 0; w--) begin
            if (way_match[w]) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[index][w]) begin
                has_invalid   = 1'b1;
                first_invalid = WAY_W'(w);
            end
        end
    end

    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_we) begin
            tag_d[index][fill_way]   = req_tag;
            valid_d[index][fill_way] = 1'b1;
            dirty_d[index][fill_way] = 1'b0;
        end
        if (dirty_we) begin
            dirty_d[index][dirty_way] = dirty_val;
        end
    end

    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end
endmodule

// File: rtl/l2_cache_ctrl.sv
// 4-way write-back/write-allocate L2 controller: data array plus hit/miss FSM.
// Define L2_PERF_CNT_EN to add hit_count/miss_count outputs.
module l2_cache_ctrl
    import l2_cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         ufp_addr,
    input  logic                ufp_read,
    input  logic                ufp_write,
    input  logic [S_BYTES-1:0]  ufp_wmask,
    input  logic [S_LINE-1:0]   ufp_wdata,
    output logic [S_LINE-1:0]   ufp_rdata,
    output logic                ufp_resp,
    output logic [31:0]         dfp_addr,
    output logic                dfp_read,
    output logic                dfp_write,
    output logic [S_LINE-1:0]   dfp_wdata,
    input  logic [S_LINE-1:0]   dfp_rdata,
    input  logic                dfp_resp,
    output logic [S_INDEX-1:0]  set_index,
    output logic                plru_we,
    output logic [WAY_W-1:0]    mru,
`ifdef L2_PERF_CNT_EN
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count,
`endif
    input  logic [WAY_W-1:0]    plru
);
    state_e                                        state_q, state_d;
    logic [S_TAG-1:0]                              req_tag_q, req_tag_d;
    logic [S_INDEX-1:0]                            req_index_q, req_index_d;
    logic [S_BYTES-1:0]                            req_wmask_q, req_wmask_d;
    logic [S_LINE-1:0]                             req_wdata_q, req_wdata_d;
    logic                                          req_write_q, req_write_d;
    logic [WAY_W-1:0]                              victim_q, victim_d;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0][S_LINE-1:0] data_q, data_d;

    addr_t                                         in_a;
    logic                                          unused_offset;
    logic                                          hit, has_invalid;
    logic [WAY_W-1:0]                              hit_way, first_invalid, victim;
    logic [NUM_WAYS-1:0][S_TAG-1:0]                way_tag;
    logic [NUM_WAYS-1:0]                           way_valid, way_dirty;
    logic                                          fill_we, dirty_we, dirty_val;
    logic [WAY_W-1:0]                              dirty_way;

    assign in_a          = split_addr(ufp_addr);
    assign unused_offset = ^in_a.offset;
    assign set_index     = (state_q == IDLE) ? in_a.index : req_index_q;

    l2_tag_store u_tags (
        .clk           (clk),
        .rst           (rst),
        .index         (req_index_q),
        .req_tag       (req_tag_q),
        .fill_we       (fill_we),
        .fill_way      (victim_q),
        .dirty_we      (dirty_we),
        .dirty_way     (dirty_way),
        .dirty_val     (dirty_val),
        .hit           (hit),
        .hit_way       (hit_way),
        .has_invalid   (has_invalid),
        .first_invalid (first_invalid),
        .way_tag       (way_tag),
        .way_valid     (way_valid),
        .way_dirty     (way_dirty)
    );

    always_comb begin
        state_d     = state_q;
        req_tag_d   = req_tag_q;
        req_index_d = req_index_q;
        req_wmask_d = req_wmask_q;
        req_wdata_d = req_wdata_q;
        req_write_d = req_write_q;
        victim_d    = victim_q;
        data_d      = data_q;
        victim      = has_invalid ? first_invalid : plru;
        ufp_rdata   = '0;
        ufp_resp    = 1'b0;
        dfp_addr    = '0;
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        dfp_wdata   = '0;
        plru_we     = 1'b0;
        mru         = '0;
        fill_we     = 1'b0;
        dirty_we    = 1'b0;
        dirty_way   = '0;
        dirty_val   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ufp_read || ufp_write) begin
                    req_tag_d   = in_a.tag;
                    req_index_d = in_a.index;
                    req_wmask_d = ufp_wmask;
                    req_wdata_d = ufp_wdata;
                    req_write_d = ufp_write;
                    state_d     = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    ufp_rdata = data_q[req_index_q][hit_way];
                    ufp_resp  = 1'b1;
                    plru_we   = 1'b1;
                    mru       = hit_way;
                    state_d   = IDLE;
                    if (req_write_q) begin
                        for (int b = 0; b < S_BYTES; b++) begin
                            if (req_wmask_q[b]) begin
                                data_d[req_index_q][hit_way][8*b +: 8] = req_wdata_q[8*b +: 8];
                            end
                        end
                        dirty_we  = 1'b1;
                        dirty_way = hit_way;
                        dirty_val = 1'b1;
                    end
                end else begin
                    victim_d = victim;
                    state_d  = (way_valid[victim] && way_dirty[victim]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                dfp_write = 1'b1;
                dfp_addr  = {way_tag[victim_q], req_index_q, {S_OFFSET{1'b0}}};
                dfp_wdata = data_q[req_index_q][victim_q];
                if (dfp_resp) begin
                    dirty_we  = 1'b1;
                    dirty_way = victim_q;
                    state_d   = ALLOCATE;
                end
            end
            ALLOCATE: begin
                dfp_read = 1'b1;
                dfp_addr = {req_tag_q, req_index_q, {S_OFFSET{1'b0}}};
                if (dfp_resp) begin
                    data_d[req_index_q][victim_q] = dfp_rdata;
                    fill_we = 1'b1;
                    state_d = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        data_q      <= data_d;
        req_wdata_q <= req_wdata_d;
        if (rst) begin
            state_q     <= IDLE;
            req_tag_q   <= '0;
            req_index_q <= '0;
            req_wmask_q <= '0;
            req_write_q <= 1'b0;
            victim_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_tag_q   <= req_tag_d;
            req_index_q <= req_index_d;
            req_wmask_q <= req_wmask_d;
            req_write_q <= req_write_d;
            victim_q    <= victim_d;
        end
    end

`ifdef L2_PERF_CNT_EN
    // The compare after a fill is the tail of a miss, not a fresh lookup.
    logic        replay_q, replay_d;
    logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

    always_comb begin
        replay_d     = replay_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == IDLE)                  replay_d = 1'b0;
        if (state_q == ALLOCATE && dfp_resp)  replay_d = 1'b1;
        if (state_q == COMPARE && !replay_q) begin
            if (hit) hit_count_d  = hit_count_q + 32'd1;
            else     miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            replay_q     <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            replay_q     <= replay_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif
endmodule
